qeciphy_tx_framer: RTL

Parametrised TX framing engine for the QECIPHY transmit path. It merges the boundary, state-control and packet-generation roles of the current fixed-width TX encoder into a single block with configurable word width, frame length and CRC group size. It adds three things the current encoder lacks: idle-fill words, a frame sequence number and a start-of-frame flag. It sits between the user AXI-Stream source and the transceiver TX data path.

---
 rtl/qeciphy_tx_pkg.sv | 36 +++
 rtl/qeciphy_tx_slot_counter.sv | 36 +++
 rtl/qeciphy_tx_framer.sv | 95 +++++++++
 3 files changed

// File: rtl/qeciphy_tx_pkg.sv
// Shared types, line-code constants and the CRC-16 helper for the QECIPHY TX framer.
package qeciphy_tx_pkg;

  typedef enum logic [1:0] {
    TX_OFF    = 2'd0,
    TX_IDLE   = 2'd1,
    TX_ACTIVE = 2'd2
  } tx_state_e;

  localparam logic [7:0]  FAW_MARKER = 8'hBC;
  localparam logic [7:0]  IDLE       = 8'h1C;
  localparam logic [7:0]  CRC_TAG    = 8'h7C;
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam int          CRC_MAX_W  = 512;

  // MSB-first CRC-16 over the low 'width' bits of 'word'.
  function automatic logic [15:0] crc16_word(input logic [15:0] crc,
                                             input logic [CRC_MAX_W-1:0] word,
                                             input int width);
    logic [15:0]          c;
    logic [CRC_MAX_W-1:0] w;
    logic                 fb;
    c = crc;
    w = word << (CRC_MAX_W - width);
    for (int i = 0; i < CRC_MAX_W; i++) begin
      if (i < width) begin
        fb = c[15] ^ w[CRC_MAX_W-1];
        c  = {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        w  = w << 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/qeciphy_tx_slot_counter.sv
// Free-running frame beat counter with FAW / CRC / payload slot decode.
module qeciphy_tx_slot_counter #(
  parameter int FAW_PERIOD = 64,
  parameter int CRC_GROUP  = 6
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic is_faw,
  output logic is_crc,
  output logic is_payload,
  output logic last_beat
);

  localparam int BEAT_W = (FAW_PERIOD > 1) ? $clog2(FAW_PERIOD) : 1;
  localparam int POS_W  = $clog2(CRC_GROUP + 1);

  logic [BEAT_W-1:0] beat_q;
  // Position inside the current CRC group, valid for beats > 0.
  logic [POS_W-1:0]  pos_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_q <= '0;
      pos_q  <= '0;
    end else begin
      beat_q <= last_beat ? '0 : beat_q + 1'b1;
      pos_q  <= (is_faw || is_crc) ? '0 : pos_q + 1'b1;
    end
  end

  assign last_beat  = (beat_q == BEAT_W'(FAW_PERIOD - 1));
  assign is_faw     = (beat_q == '0);
  assign is_crc     = !is_faw && (pos_q == POS_W'(CRC_GROUP));
  assign is_payload = !is_faw && !is_crc;

endmodule

// File: rtl/qeciphy_tx_framer.sv
// QECIPHY TX framer: FAW / payload / CRC framing with idle fill and frame sequence number.
module qeciphy_tx_framer
  import qeciphy_tx_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int FAW_PERIOD = 64,
  parameter int CRC_GROUP  = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] s_axis_tdata_i,
  input  logic              s_axis_tvalid_i,
  output logic              s_axis_tready_o,
  output logic [DATA_W-1:0] m_axis_tdata_o,
  output logic              m_sof_o,
  input  logic              link_enable_i,
  input  logic              data_enable_i,
  input  logic              rx_rdy_i
);

  localparam logic [DATA_W-1:0]  IDLE_WORD = {(DATA_W/8){IDLE}};
  localparam logic [DATA_W-17:0] FAW_HI    = {(DATA_W/8-2){FAW_MARKER}};

  logic is_faw, is_crc, is_payload, last_beat;

  tx_state_e         state_q, state_d;
  logic [7:0]        seq_q, seq_d;
  logic [15:0]       crc_q, crc_d;
  logic [DATA_W-1:0] payload_p0, word_p0;
  logic              sof_p0;

  qeciphy_tx_slot_counter #(
    .FAW_PERIOD(FAW_PERIOD),
    .CRC_GROUP (CRC_GROUP)
  ) u_slot (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .is_faw    (is_faw),
    .is_crc    (is_crc),
    .is_payload(is_payload),
    .last_beat (last_beat)
  );

  assign s_axis_tready_o = (state_q == TX_ACTIVE) && is_payload;

  // p0: assemble the word for the current slot
  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    crc_d      = crc_q;
    word_p0    = '0;
    sof_p0     = 1'b0;
    payload_p0 = ((state_q == TX_ACTIVE) && s_axis_tvalid_i) ? s_axis_tdata_i : IDLE_WORD;

    if (last_beat) begin
      if (!link_enable_i)      state_d = TX_OFF;
      else if (!data_enable_i) state_d = TX_IDLE;
      else                     state_d = TX_ACTIVE;
    end

    if (state_q == TX_OFF) begin
      seq_d = 8'd0;
      crc_d = CRC16_INIT;
    end else if (is_faw) begin
      word_p0 = {FAW_HI, seq_q, 7'b0, rx_rdy_i};
      sof_p0  = 1'b1;
      seq_d   = seq_q + 8'd1;
      crc_d   = CRC16_INIT;
    end else if (is_crc) begin
      word_p0 = {CRC_TAG, {(DATA_W-24){1'b0}}, crc_q};
      crc_d   = CRC16_INIT;
    end else begin
      word_p0 = payload_p0;
      crc_d   = crc16_word(crc_q, CRC_MAX_W'(payload_p0), DATA_W);
    end
  end

  // p1: registered line word
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= TX_OFF;
      seq_q          <= 8'd0;
      crc_q          <= CRC16_INIT;
      m_axis_tdata_o <= '0;
      m_sof_o        <= 1'b0;
    end else begin
      state_q        <= state_d;
      seq_q          <= seq_d;
      crc_q          <= crc_d;
      m_axis_tdata_o <= word_p0;
      m_sof_o        <= sof_p0;
    end
  end

endmodule
